// File: rtl/disp_arbiter_if.sv
// Bundles the request/data side and the display side of the display arbiter.
// The master modport is the requesting environment.
// The slave modport is the arbiter itself.
interface disp_arbiter_if #(
    parameter int W = 16
);
    logic         tick;
    logic [1:0]   req;
    logic [W-1:0] data0;
    logic [W-1:0] data1;
    logic [W-1:0] data;
    logic [1:0]   grant;
    logic         blank;

    modport master (
        output tick,
        output req,
        output data0,
        output data1,
        input  data,
        input  grant,
        input  blank
    );

    modport slave (
        input  tick,
        input  req,
        input  data0,
        input  data1,
        output data,
        output grant,
        output blank
    );
endinterface

// File: rtl/disp_arbiter.sv
// Two-source arbiter for a shared hex display.
// While both sources request, the grant is time-sliced using tick pulses.
// A lone requester keeps the display for as long as it keeps requesting.
// All outputs are registered, so there is no combinational path from inputs to outputs.
module disp_arbiter #(
    parameter int W     = 16,
    parameter int DWELL = 8
) (
    input logic            clk,
    input logic            rst,
    disp_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    // The dwell counter saturates here; the tick that arrives while the count
    // sits at this value is the DWELL-th tick and hands the display over.
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t       r_state;
    state_t       w_nextState;
    logic [7:0]   r_dwell;
    logic [7:0]   w_nextDwell;
    logic         r_lastOwner;
    logic         w_nextLastOwner;
    logic [1:0]   r_grant;
    logic [1:0]   w_nextGrant;
    logic         r_blank;
    logic [W-1:0] r_data;

    // Next-state, dwell and last-owner logic; a dropped own request is checked before dwell expiry
    always_comb begin
        w_nextState     = r_state;
        w_nextDwell     = 8'd0;
        w_nextLastOwner = r_lastOwner;
        w_nextGrant     = 2'b00;

        case (r_state)
            S_IDLE: begin
                case (bus.req)
                    2'b01:   w_nextState = S_OWN0;
                    2'b10:   w_nextState = S_OWN1;
                    2'b11:   w_nextState = r_lastOwner ? S_OWN0 : S_OWN1;
                    default: w_nextState = S_IDLE;
                endcase
            end
            S_OWN0: begin
                if (!bus.req[0]) begin
                    w_nextState = bus.req[1] ? S_OWN1 : S_IDLE;
                end else if (!bus.req[1]) begin
                    w_nextDwell = 8'd0;
                end else if (bus.tick) begin
                    if (r_dwell >= DWELL_LAST) begin
                        w_nextState = S_OWN1;
                    end else begin
                        w_nextDwell = r_dwell + 8'd1;
                    end
                end else begin
                    w_nextDwell = r_dwell;
                end
            end
            S_OWN1: begin
                if (!bus.req[1]) begin
                    w_nextState = bus.req[0] ? S_OWN0 : S_IDLE;
                end else if (!bus.req[0]) begin
                    w_nextDwell = 8'd0;
                end else if (bus.tick) begin
                    if (r_dwell >= DWELL_LAST) begin
                        w_nextState = S_OWN0;
                    end else begin
                        w_nextDwell = r_dwell + 8'd1;
                    end
                end else begin
                    w_nextDwell = r_dwell;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase

        if (w_nextState != r_state) begin
            w_nextDwell = 8'd0;
        end

        case (w_nextState)
            S_OWN0: begin
                w_nextLastOwner = 1'b0;
                w_nextGrant     = 2'b01;
            end
            S_OWN1: begin
                w_nextLastOwner = 1'b1;
                w_nextGrant     = 2'b10;
            end
            default: begin
                w_nextGrant     = 2'b00;
            end
        endcase
    end

    // State, dwell counter, last owner and grant all move together on the clock edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dwell     <= 8'd0;
            r_lastOwner <= 1'b1;
            r_grant     <= 2'b00;
        end else begin
            r_state     <= w_nextState;
            r_dwell     <= w_nextDwell;
            r_lastOwner <= w_nextLastOwner;
            r_grant     <= w_nextGrant;
        end
    end

    // Display side: blank and data follow the current owner one cycle later; idle holds the last value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blank <= 1'b1;
            r_data  <= '0;
        end else begin
            r_blank <= (r_state == S_IDLE);
            case (r_state)
                S_OWN0:  r_data <= bus.data0;
                S_OWN1:  r_data <= bus.data1;
                default: r_data <= r_data;
            endcase
        end
    end

    assign bus.grant = r_grant;
    assign bus.blank = r_blank;
    assign bus.data  = r_data;

endmodule

// File: tb/tb_disp_arbiter.sv
// Scoreboard testbench for disp_arbiter.
// The stimulus side pushes expected outputs from an owner/tick-count model.
// A negedge monitor pops one entry per cycle and compares it with the DUT.
module tb_disp_arbiter;

    localparam int W     = 16;
    localparam int DWELL = 8;

    typedef struct {
        logic [1:0]   grant;
        logic         blank;
        logic [W-1:0] data;
    } expect_t;

    logic clk;
    logic rst;

    disp_arbiter_if #(.W(W)) bus ();

    disp_arbiter #(.W(W), .DWELL(DWELL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    expect_t expQ[$];
    int compared   = 0;
    int mismatched = 0;

    // Reference model: owner is -1 (nobody), 0 or 1.
    // ticksSeen counts ticks during contention.
    int           mOwner;
    int           mLast;
    int           mTicksSeen;
    logic         mBlank;
    logic [W-1:0] mData;

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the model by one clock edge given the inputs present before it
    task automatic modelStep(input logic r, input logic t, input logic [1:0] q,
                             input logic [W-1:0] d0, input logic [W-1:0] d1);
        int nxt;
        int other;
        if (r) begin
            mOwner = -1; mLast = 1; mTicksSeen = 0; mBlank = 1'b1; mData = '0;
            return;
        end
        mBlank = (mOwner < 0);
        if (mOwner == 0) mData = d0;
        else if (mOwner == 1) mData = d1;
        nxt = mOwner;
        if (mOwner < 0) begin
            if (q == 2'b01) nxt = 0;
            else if (q == 2'b10) nxt = 1;
            else if (q == 2'b11) nxt = 1 - mLast;
        end else begin
            other = 1 - mOwner;
            if (!q[mOwner]) begin
                nxt = q[other] ? other : -1;
            end else if (!q[other]) begin
                mTicksSeen = 0;
            end else if (t) begin
                mTicksSeen++;
                if (mTicksSeen == DWELL) nxt = other;
            end
        end
        if (nxt != mOwner) begin
            mTicksSeen = 0;
            if (nxt >= 0) mLast = nxt;
        end
        mOwner = nxt;
    endtask

    // Drive one cycle of inputs and push the expected post-edge outputs
    task automatic applyStimulus(input logic r, input logic t, input logic [1:0] q,
                                 input logic [W-1:0] d0, input logic [W-1:0] d1);
        expect_t e;
        @(negedge clk);
        #1;
        rst       = r;
        bus.tick  = t;
        bus.req   = q;
        bus.data0 = d0;
        bus.data1 = d1;
        modelStep(r, t, q, d0, d1);
        e.grant = (mOwner == 0) ? 2'b01 : (mOwner == 1) ? 2'b10 : 2'b00;
        e.blank = mBlank;
        e.data  = mData;
        expQ.push_back(e);
    endtask

    // Compare one field and report a failure line
    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            if (mismatched <= 30)
                $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: one expected entry per clock edge, sampled on the falling edge
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("grant", W'(bus.grant), W'(e.grant));
                checkOutput("blank", W'(bus.blank), W'(e.blank));
                checkOutput("data",  bus.data,      e.data);
            end
        end
    end

    // Stimulus sequence: directed scenarios followed by a random soak
    initial begin
        int waitCycles;
        rst = 1'b1; bus.tick = 1'b0; bus.req = 2'b00; bus.data0 = '0; bus.data1 = '0;
        mOwner = -1; mLast = 1; mTicksSeen = 0; mBlank = 1'b1; mData = '0;

        repeat (2) applyStimulus(1'b1, 1'b0, 2'b00, 16'h0, 16'h0);

        // Single requester on source 0
        repeat (4) applyStimulus(1'b0, 1'b0, 2'b01, 16'h1234, 16'hBEEF);

        // Contention with a tick every 4 clocks: alternation every DWELL ticks
        for (int i = 0; i < 80; i++)
            applyStimulus(1'b0, (i % 4) == 3, 2'b11, W'($urandom), W'($urandom));

        // Own source 0, contend for 3 ticks, then source 0 drops out
        repeat (3) applyStimulus(1'b0, 1'b0, 2'b01, 16'h0A0A, 16'h0B0B);
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b0, (i % 4) == 3, 2'b11, 16'h0A0A, 16'h0B0B);
        for (int i = 0; i < 40; i++)
            applyStimulus(1'b0, (i % 4) == 3, 2'b10, W'($urandom), W'($urandom));

        // Lone source 1 for 100 ticks, data tracking with one cycle lag
        for (int i = 0; i < 200; i++)
            applyStimulus(1'b0, i[0], 2'b10, W'($urandom), W'($urandom));

        // Everybody drops out: blank, data holds; then contention resumes
        repeat (5) applyStimulus(1'b0, 1'b1, 2'b00, W'($urandom), W'($urandom));
        repeat (5) applyStimulus(1'b0, 1'b0, 2'b11, W'($urandom), W'($urandom));

        // Reset on a tick while source 1 owns the display
        repeat (3) applyStimulus(1'b0, 1'b0, 2'b10, 16'h5555, 16'h6666);
        applyStimulus(1'b1, 1'b1, 2'b11, 16'h5555, 16'h6666);
        repeat (4) applyStimulus(1'b0, 1'b0, 2'b11, 16'h7777, 16'h8888);

        // Random soak with held request patterns and sporadic resets
        for (int blk = 0; blk < 150; blk++) begin
            logic [1:0] q;
            int len;
            q   = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++)
                applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0), q,
                              W'($urandom), W'($urandom));
        end

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 10) begin
            @(negedge clk);
            waitCycles++;
        end
        #1;
        if (expQ.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
